// File: rtl/controle_enchimento_if.sv
// Sensor, command and status bundle of the automatic tank-fill controller.
// master = sensor/operator side that drives inputs, slave = the controller.
interface controle_enchimento_if;
  logic       habilita;
  logic       manual;
  logic       sensor_baixo;
  logic       sensor_alto;
  logic       reconhece;
  logic       abre_auto;
  logic       fecha_auto;
  logic       falha;
  logic [1:0] estado;

  modport master (
    output habilita, manual, sensor_baixo, sensor_alto, reconhece,
    input  abre_auto, fecha_auto, falha, estado
  );

  modport slave (
    input  habilita, manual, sensor_baixo, sensor_alto, reconhece,
    output abre_auto, fecha_auto, falha, estado
  );
endinterface

// File: rtl/controle_enchimento.sv
// Automatic fill controller: synchronizes and debounces the level sensors, then
// runs a Moore FSM opening the inlet valve below the low mark and closing it on full/timeout/fault.
module controle_enchimento #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 20,
  parameter int ESPERA_CICLOS   = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  controle_enchimento_if.slave bus
);

  localparam int CW   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam int TMAX = (TIMEOUT_CICLOS > ESPERA_CICLOS) ? TIMEOUT_CICLOS : ESPERA_CICLOS;
  localparam int TW   = $clog2(TMAX + 1);

  // Bit 0 = low sensor, bit 1 = high sensor; reset reads as a full tank.
  localparam logic [1:0] SENS_RST = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENCHENDO = 2'd1,
    ESPERA   = 2'd2,
    FALHA    = 2'd3
  } estado_t;

  logic [1:0]    raw;
  logic [1:0]    s1_q, s2_q, f_q, f_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          abre_q, abre_d;
  logic          fecha_q, fecha_d;
  logic          falha_q, falha_d;

  logic baixo_f, alto_f, contra;

  assign raw     = {bus.sensor_alto, bus.sensor_baixo};
  assign baixo_f = f_q[0];
  assign alto_f  = f_q[1];
  assign contra  = baixo_f & alto_f;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      f_d[i]   = f_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
          f_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= SENS_RST;
      s2_q     <= SENS_RST;
      f_q      <= SENS_RST;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      f_q      <= f_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (contra)                                                 estado_d = FALHA;
        else if (bus.habilita && !bus.manual && baixo_f && !alto_f) estado_d = ENCHENDO;
      end
      ENCHENDO: begin
        if (contra)                                   estado_d = FALHA;
        else if (bus.manual || !bus.habilita)         estado_d = ESPERA;
        else if (alto_f)                              estado_d = ESPERA;
        else if (timer_q == TW'(TIMEOUT_CICLOS - 1))  estado_d = FALHA;
      end
      ESPERA: begin
        if (timer_q == TW'(ESPERA_CICLOS - 1)) estado_d = OCIOSO;
      end
      FALHA: begin
        if (bus.reconhece && !contra) estado_d = ESPERA;
      end
      default: estado_d = OCIOSO;
    endcase

    // Timer restarts on every transition and saturates instead of wrapping.
    if (estado_d != estado_q)  timer_d = '0;
    else if (timer_q != '1)    timer_d = timer_q + TW'(1);
    else                       timer_d = timer_q;

    abre_d  = (estado_d == ENCHENDO);
    fecha_d = (estado_d == ESPERA) || (estado_d == FALHA);
    falha_d = (estado_d == FALHA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
      abre_q   <= 1'b0;
      fecha_q  <= 1'b0;
      falha_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      abre_q   <= abre_d;
      fecha_q  <= fecha_d;
      falha_q  <= falha_d;
    end
  end

  assign bus.abre_auto  = abre_q;
  assign bus.fecha_auto = fecha_q;
  assign bus.falha      = falha_q;
  assign bus.estado     = estado_q;

endmodule

// File: tb/tb_controle_enchimento.sv
// Bench for controle_enchimento: scripted scenarios with a queue of expected
// state transitions consumed by a monitor, plus inline output checks.
module tb_controle_enchimento;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  controle_enchimento_if bus ();

  controle_enchimento #(
    .DEBOUNCE_CICLOS(4),
    .TIMEOUT_CICLOS (20),
    .ESPERA_CICLOS  (8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {estado, abre_auto, fecha_auto, falha}
  localparam logic [4:0] O_OCIOSO   = 5'b00_0_0_0;
  localparam logic [4:0] O_ENCHENDO = 5'b01_1_0_0;
  localparam logic [4:0] O_ESPERA   = 5'b10_0_1_0;
  localparam logic [4:0] O_FALHA    = 5'b11_0_1_1;

  logic [4:0] obs;
  assign obs = {bus.estado, bus.abre_auto, bus.fecha_auto, bus.falha};

  logic [1:0] exp_q[$];
  logic [1:0] prev_est;
  logic [1:0] exp_est;
  logic       mon_en;

  // Scoreboard: every estado change must match the next queued expectation,
  // and the outputs must always be the decode of estado.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (bus.abre_auto !== (bus.estado == 2'd1) || bus.fecha_auto !== bus.estado[1] ||
          bus.falha !== (bus.estado == 2'd3)) begin
        failures++;
        $display("FAIL decode estado=%0d abre=%b fecha=%b falha=%b", bus.estado,
                 bus.abre_auto, bus.fecha_auto, bus.falha);
      end
      if (bus.estado !== prev_est) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%0d from=%0d want=no_change", bus.estado, prev_est);
        end else begin
          exp_est = exp_q.pop_front();
          if (bus.estado !== exp_est) begin
            failures++;
            $display("FAIL sb_transition got=%0d want=%0d", bus.estado, exp_est);
          end
        end
        prev_est = bus.estado;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n          = 1'b1;
    bus.habilita     = 1'b0;
    bus.manual       = 1'b0;
    bus.sensor_baixo = 1'b0;
    bus.sensor_alto  = 1'b1;
    bus.reconhece    = 1'b0;
    mon_en           = 1'b0;
    prev_est         = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, O_OCIOSO);
    end
    tick(2);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick(3);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL reset_idle got=%b want=%b", obs, O_OCIOSO);
    end
  endtask

  task automatic test_fill_start;
    bus.sensor_baixo = 1'b1;
    bus.sensor_alto  = 1'b0;
    bus.habilita     = 1'b1;
    exp_q.push_back(2'd1);
    tick(6);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL fill_early got=%b want=%b", obs, O_OCIOSO);
    end
    tick(1);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL fill_entry got=%b want=%b", obs, O_ENCHENDO);
    end
  endtask

  task automatic test_glitch;
    bus.sensor_alto = 1'b1;
    tick(3);
    bus.sensor_alto = 1'b0;
    tick(6);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL glitch_ignored got=%b want=%b", obs, O_ENCHENDO);
    end
  endtask

  task automatic test_high;
    bus.sensor_baixo = 1'b0;
    bus.sensor_alto  = 1'b1;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    tick(6);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL high_early got=%b want=%b", obs, O_ENCHENDO);
    end
    tick(1);
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL high_close got=%b want=%b", obs, O_ESPERA);
    end
    tick(7);
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL high_wait_hold got=%b want=%b", obs, O_ESPERA);
    end
    tick(1);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL high_wait_end got=%b want=%b", obs, O_OCIOSO);
    end
    tick(3);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL high_no_reentry got=%b want=%b", obs, O_OCIOSO);
    end
  endtask

  task automatic test_timeout;
    bus.sensor_baixo = 1'b1;
    bus.sensor_alto  = 1'b0;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    tick(7);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL to_entry got=%b want=%b", obs, O_ENCHENDO);
    end
    tick(19);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL to_last_fill got=%b want=%b", obs, O_ENCHENDO);
    end
    tick(1);
    checks++;
    if (obs !== O_FALHA) begin
      failures++;
      $display("FAIL to_fault got=%b want=%b", obs, O_FALHA);
    end
    tick(3);
    checks++;
    if (obs !== O_FALHA) begin
      failures++;
      $display("FAIL to_fault_hold got=%b want=%b", obs, O_FALHA);
    end
    bus.reconhece = 1'b1;
    bus.habilita  = 1'b0;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    tick(1);
    bus.reconhece = 1'b0;
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL to_ack got=%b want=%b", obs, O_ESPERA);
    end
    tick(7);
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL to_wait_hold got=%b want=%b", obs, O_ESPERA);
    end
    tick(1);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL to_wait_end got=%b want=%b", obs, O_OCIOSO);
    end
  endtask

  task automatic test_contra;
    bus.sensor_alto = 1'b1;
    exp_q.push_back(2'd3);
    tick(6);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL contra_early got=%b want=%b", obs, O_OCIOSO);
    end
    tick(1);
    checks++;
    if (obs !== O_FALHA) begin
      failures++;
      $display("FAIL contra_fault got=%b want=%b", obs, O_FALHA);
    end
    bus.reconhece = 1'b1;
    tick(2);
    checks++;
    if (obs !== O_FALHA) begin
      failures++;
      $display("FAIL contra_ack_blocked got=%b want=%b", obs, O_FALHA);
    end
    bus.sensor_baixo = 1'b0;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    tick(6);
    checks++;
    if (obs !== O_FALHA) begin
      failures++;
      $display("FAIL contra_clearing got=%b want=%b", obs, O_FALHA);
    end
    tick(1);
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL contra_exit got=%b want=%b", obs, O_ESPERA);
    end
    bus.reconhece = 1'b0;
    tick(8);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL contra_idle got=%b want=%b", obs, O_OCIOSO);
    end
  endtask

  task automatic test_manual;
    bus.sensor_baixo = 1'b1;
    bus.sensor_alto  = 1'b0;
    bus.habilita     = 1'b1;
    exp_q.push_back(2'd1);
    tick(7);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL man_entry got=%b want=%b", obs, O_ENCHENDO);
    end
    bus.manual = 1'b1;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    tick(1);
    checks++;
    if (obs !== O_ESPERA) begin
      failures++;
      $display("FAIL man_yield got=%b want=%b", obs, O_ESPERA);
    end
    tick(8);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL man_wait_end got=%b want=%b", obs, O_OCIOSO);
    end
    tick(4);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL man_blocks_entry got=%b want=%b", obs, O_OCIOSO);
    end
    bus.manual = 1'b0;
    exp_q.push_back(2'd1);
    tick(1);
    checks++;
    if (obs !== O_ENCHENDO) begin
      failures++;
      $display("FAIL man_release got=%b want=%b", obs, O_ENCHENDO);
    end
  endtask

  task automatic test_reset_mid_fill;
    tick(2);
    exp_q.push_back(2'd0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL rst_async got=%b want=%b", obs, O_OCIOSO);
    end
    bus.habilita = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    checks++;
    if (obs !== O_OCIOSO) begin
      failures++;
      $display("FAIL rst_after got=%b want=%b", obs, O_OCIOSO);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_start();
    test_glitch();
    test_high();
    test_timeout();
    test_contra();
    test_manual();
    test_reset_mid_fill();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_pending got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
